// File: rtl/bitrev_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : bitrev_addr_gen
// Brief    : Ping-pong address pair generator for FFT reordering. Reads the
//            source bank in natural order and writes the destination bank in
//            natural or bit-reversed order over a per-frame length 2^len_log2.
// Revision : 1.0  initial release
// ============================================================================
module bitrev_addr_gen #(
  parameter int LOG2N = 3,
  parameter int LEN_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len_log2,
  input  logic             mode,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [LOG2N-1:0] rd_addr,
  output logic [LOG2N-1:0] wr_addr,
  output logic             rd_bank,
  output logic             wr_bank,
  output logic             last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Largest legal length exponent, also the value held in len_q after reset.
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(LOG2N);

  state_t           state, state_nxt;
  logic [LOG2N-1:0] cnt, cnt_nxt;
  logic [LEN_W-1:0] len_q, len_nxt;
  logic             mode_q, mode_nxt;
  logic             bank_q, bank_nxt;

  logic [LEN_W-1:0] len_clamped;
  logic [LOG2N-1:0] len_mask;
  logic [LOG2N-1:0] cnt_rev;
  logic             handshake;

  // Oversized requests run at the full transform length.
  assign len_clamped = (len_log2 > LEN_MAX) ? LEN_MAX : len_log2;

  // Length mask (equals L-1) and cnt reversed over the low len bits; bits at
  // or above len stay zero because only in-range positions are assigned.
  always_comb begin
    len_mask = '0;
    cnt_rev  = '0;
    for (int i = 0; i < LOG2N; i++) begin
      if (i < int'(len_q)) begin
        len_mask[i] = 1'b1;
        for (int j = 0; j < LOG2N; j++) begin
          if (j == int'(len_q) - 1 - i) begin
            cnt_rev[i] = cnt[j];
          end
        end
      end
    end
  end

  assign out_valid = (state == S_RUN);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign last      = (state == S_RUN) && (cnt == len_mask);
  assign rd_addr   = cnt;
  assign wr_addr   = mode_q ? cnt_rev : cnt;
  assign rd_bank   = bank_q;
  assign wr_bank   = ~bank_q;
  assign handshake = out_valid & out_ready;

  // Next-state logic: frame acceptance, counter advance and bank swap.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    len_nxt   = len_q;
    mode_nxt  = mode_q;
    bank_nxt  = bank_q;
    case (state)
      S_IDLE: begin
        if (start && (len_log2 != '0)) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
          len_nxt   = len_clamped;
          mode_nxt  = mode;
        end
      end
      S_RUN: begin
        if (handshake) begin
          if (last) begin
            state_nxt = S_DONE;
            cnt_nxt   = '0;
            bank_nxt  = ~bank_q;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      len_q  <= LEN_MAX;
      mode_q <= 1'b0;
      bank_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      len_q  <= len_nxt;
      mode_q <= mode_nxt;
      bank_q <= bank_nxt;
    end
  end

endmodule
`default_nettype wire
